// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Load handshake and serial output bundle for piso_serializer.
//  Revision    : 1.0
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    // master = word producer / serial observer, slave = the serializer
    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output ser_out,
        output ser_valid,
        output frame_start,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in/serial-out transmitter with valid/ready load and
//                registered serial output; optional even-parity slot under
//                the PARITY_EN macro.
//  Revision    : 1.0
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    piso_serializer_if.slave bus
);

    localparam int                c_cnt_w     = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               frame_start_q, frame_start_d;
`ifdef PARITY_EN
    logic               par_q, par_d;
`endif

    logic w_last_bit;
    logic w_load_ready;
    logic w_accept;

    // Bit presented next, and the word left once that bit has gone out.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

`ifdef PARITY_EN
    assign w_last_bit = (state_q == ST_PAR);
`else
    assign w_last_bit = (state_q == ST_SHIFT) && (cnt_q == c_last_data);
`endif

    assign w_load_ready = ((state_q == ST_IDLE) || w_last_bit) && rst_n;
    assign w_accept     = bus.load_valid && w_load_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
`ifdef PARITY_EN
        par_d         = par_q;
`endif
        if (w_accept) begin
            // Covers both a fresh start from IDLE and a back-to-back reload.
            state_d       = ST_SHIFT;
            cnt_d         = '0;
            shreg_d       = advance(bus.load_data);
            ser_out_d     = head_bit(bus.load_data);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef PARITY_EN
            par_d         = ^bus.load_data;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != c_last_data) begin
                        cnt_d       = cnt_q + c_cnt_one;
                        ser_out_d   = head_bit(shreg_q);
                        shreg_d     = advance(shreg_q);
                        ser_valid_d = 1'b1;
                    end else begin
`ifdef PARITY_EN
                        state_d     = ST_PAR;
                        cnt_d       = cnt_q + c_cnt_one;
                        ser_out_d   = par_q;
                        ser_valid_d = 1'b1;
`else
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
`endif
                    end
                end
                ST_PAR: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
`ifdef PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign bus.load_ready  = w_load_ready;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a frame-queue model.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data  = '0;
    int               checks     = 0;
    int               errors     = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(WIDTH)) ia ();
    piso_serializer_if #(.WIDTH(WIDTH)) ib ();

    assign ia.load_valid = load_valid;
    assign ia.load_data  = load_data;
    assign ib.load_valid = load_valid;
    assign ib.load_data  = load_data;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds every output slot still owed for accepted words.
    typedef struct packed {
        logic a;
        logic b;
        logic s;
    } slot_t;

    slot_t mq[$];
    slot_t cur   = '0;
    logic  cur_v = 1'b0;
    bit    m_acc = 1'b0;

    always @(posedge clk) begin
        bit rdy;
        rdy   = rst_n && (mq.size() == 0);
        m_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            cur   = '0;
            cur_v = 1'b0;
        end else begin
            if (load_valid && rdy) begin
                m_acc = 1'b1;
                for (int i = 0; i < WIDTH; i++)
                    mq.push_back('{a: load_data[WIDTH-1-i], b: load_data[i], s: (i == 0)});
`ifdef PARITY_EN
                mq.push_back('{a: ^load_data, b: ^load_data, s: 1'b0});
`endif
            end
            if (mq.size() > 0) begin
                cur   = mq.pop_front();
                cur_v = 1'b1;
            end else begin
                cur   = '0;
                cur_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic mrdy;
        mrdy = rst_n && (mq.size() == 0);
        chk("msb_ser_out",     ia.ser_out,     cur.a);
        chk("msb_ser_valid",   ia.ser_valid,   cur_v);
        chk("msb_frame_start", ia.frame_start, cur.s);
        chk("msb_busy",        ia.busy,        cur_v);
        chk("msb_load_ready",  ia.load_ready,  mrdy);
        chk("lsb_ser_out",     ib.ser_out,     cur.b);
        chk("lsb_ser_valid",   ib.ser_valid,   cur_v);
        chk("lsb_frame_start", ib.frame_start, cur.s);
        chk("lsb_load_ready",  ib.load_ready,  mrdy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1 with the DUT idle; w0 is accepted at the next edge.
    task automatic capture(input logic [WIDTH-1:0] w0, input bit two, input logic [WIDTH-1:0] w1,
                           input int n, output logic [63:0] a, output logic [63:0] b,
                           output logic [63:0] fs, output logic [63:0] sv,
                           output logic [63:0] bz, output logic [63:0] rd);
        a = '0; b = '0; fs = '0; sv = '0; bz = '0; rd = '0;
        load_valid = 1'b1;
        load_data  = w0;
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0 && two) begin
                load_data = w1;
            end else if ((k == 0 && !two) || (two && k == FLEN)) begin
                load_valid = 1'b0;
                load_data  = WIDTH'($urandom);
            end
            @(negedge clk);
            a[k]  = ia.ser_out;
            b[k]  = ib.ser_out;
            fs[k] = ia.frame_start;
            sv[k] = ia.ser_valid;
            bz[k] = ia.busy;
            rd[k] = ia.load_ready;
        end
    endtask

    initial begin
        logic [63:0] a, b, fs, sv, bz, rd;
        logic [63:0] one_frame;
        bit          pending;
        one_frame = (64'd1 << FLEN) - 64'd1;

        // Reset held for three edges with a word offered.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ser_valid",  ia.ser_valid,  64'd0);
            chk("rst_ser_out",    ia.ser_out,    64'd0);
            chk("rst_busy",       ia.busy,       64'd0);
            chk("rst_load_ready", ia.load_ready, 64'd0);
        end
        #1;
        rst_n      = 1'b1;
        load_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle_ser_valid",  ia.ser_valid,  64'd0);
            chk("idle_load_ready", ia.load_ready, 64'd1);
        end

        // A5: MSB first 1,0,1,0,0,1,0,1 (palindrome, so LSB first matches).
        step();
        capture(8'hA5, 1'b0, 8'h00, FLEN + 1, a, b, fs, sv, bz, rd);
        chk("a5_msb_bits",    a,  64'h0A5);
        chk("a5_lsb_bits",    b,  64'h0A5);
        chk("a5_frame_start", fs, 64'h1);
        chk("a5_ser_valid",   sv, one_frame);
        chk("a5_busy",        bz, one_frame);

        // 01: LSB first leads with the 1, MSB first ends with it.
        step();
        capture(8'h01, 1'b0, 8'h00, FLEN + 1, a, b, fs, sv, bz, rd);
`ifdef PARITY_EN
        chk("w01_msb_bits", a, 64'h180);
        chk("w01_lsb_bits", b, 64'h101);
`else
        chk("w01_msb_bits", a, 64'h080);
        chk("w01_lsb_bits", b, 64'h001);
`endif
        chk("w01_ser_valid", sv, one_frame);

        // FF then 00 back to back.
        step();
        capture(8'hFF, 1'b1, 8'h00, 2 * FLEN + 1, a, b, fs, sv, bz, rd);
        chk("b2b_ser_valid",   sv, (64'd1 << (2 * FLEN)) - 64'd1);
        chk("b2b_frame_start", fs, 64'd1 | (64'd1 << FLEN));
        chk("b2b_load_ready",  rd, (64'd1 << (FLEN - 1)) | (64'd1 << (2 * FLEN - 1)) | (64'd1 << (2 * FLEN)));
        chk("b2b_msb_bits",    a,  64'h0FF);
        chk("b2b_lsb_bits",    b,  64'h0FF);

        // C3 aborted by reset during its 4th bit, then 3C sent cleanly.
        step();
        capture(8'hC3, 1'b0, 8'h00, 4, a, b, fs, sv, bz, rd);
        chk("c3_first4", a, 64'h3);
        #1;
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        @(negedge clk);
        chk("abort_ser_valid",  ia.ser_valid,  64'd0);
        chk("abort_busy",       ia.busy,       64'd0);
        chk("abort_load_ready", ia.load_ready, 64'd0);
        step();
        rst_n = 1'b1;
        capture(8'h3C, 1'b0, 8'h00, FLEN + 1, a, b, fs, sv, bz, rd);
        chk("w3c_msb_bits",    a,  64'h03C);
        chk("w3c_frame_start", fs, 64'h1);
        chk("w3c_ser_valid",   sv, one_frame);

`ifdef PARITY_EN
        step();
        capture(8'h07, 1'b0, 8'h00, FLEN + 1, a, b, fs, sv, bz, rd);
        chk("par07_msb_bits", a, 64'h1E0);
        step();
        capture(8'h03, 1'b0, 8'h00, FLEN + 1, a, b, fs, sv, bz, rd);
        chk("par03_msb_bits", a, 64'h0C0);
`endif

        // Randomised traffic with held-off words and occasional resets.
        pending = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (pending && m_acc)
                pending = 1'b0;
            rst_n = ($urandom_range(0, 149) != 0);
            if (!pending) begin
                if ($urandom_range(0, 2) != 0) begin
                    load_valid = 1'b1;
                    load_data  = WIDTH'($urandom);
                    pending    = 1'b1;
                end else begin
                    load_valid = 1'b0;
                    load_data  = WIDTH'($urandom);
                end
            end
        end
        step();
        rst_n      = 1'b1;
        load_valid = 1'b0;
        repeat (2 * FLEN + 2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
